// File: rtl/sdram_port_arbiter_if.sv
// Byte-port bundle shared by the two arbiter clients and the SDRAM side.
// Toggle handshake: the master flips req to start a transfer, and the slave flips ack
// (making ack == req) when the transfer is complete.
//   req : master -> slave  toggle request
//   ack : slave -> master  toggle acknowledge
//   we  : master -> slave  write enable
//   a   : master -> slave  byte address, a_bits wide
//   d   : master -> slave  write data
//   q   : slave -> master  read data
interface sdram_port_arbiter_if #(
  parameter int unsigned a_bits = 24
);
  logic              req;
  logic              ack;
  logic              we;
  logic [a_bits-1:0] a;
  logic [7:0]        d;
  logic [7:0]        q;

  modport master (output req, we, a, d, input ack, q);
  modport slave  (input req, we, a, d, output ack, q);
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter in front of a single SDRAM byte port (sysclk domain).
// At most one RAM transaction is outstanding at a time. When both clients are pending,
// the client that was not granted last wins.
//   clk     : system clock; all logic is clocked on the rising edge
//   reset_n : synchronous active-low reset
//   a       : client A (DMA engine), slave side of the toggle handshake
//   b       : client B (MMC64), slave side of the toggle handshake
//   ram     : SDRAM byte port, master side of the toggle handshake
module sdram_port_arbiter #(
  parameter int unsigned a_bits = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_port_arbiter_if.slave  a,
  sdram_port_arbiter_if.slave  b,
  sdram_port_arbiter_if.master ram
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [a_bits-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [7:0]        a_rdata_q, a_rdata_d;
  logic [7:0]        b_rdata_q, b_rdata_d;
  // Last (and, during a transaction, current) grant: 1 = client B.
  logic              grant_b_q, grant_b_d;

  logic a_pend, b_pend;

  assign a_pend = a.req ^ a_ack_q;
  assign b_pend = b.req ^ b_ack_q;

  assign ram.req = ram_req_q;
  assign ram.we  = ram_we_q;
  assign ram.a   = ram_addr_q;
  assign ram.d   = ram_wdata_q;
  assign a.ack   = a_ack_q;
  assign a.q     = a_rdata_q;
  assign b.ack   = b_ack_q;
  assign b.q     = b_rdata_q;

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    a_ack_d     = a_ack_q;
    b_ack_d     = b_ack_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    grant_b_d   = grant_b_q;

    case (state_q)
      StIdle: begin
        if (a_pend && (!b_pend || grant_b_q)) begin
          grant_b_d   = 1'b0;
          ram_we_d    = a.we;
          ram_addr_d  = a.a;
          ram_wdata_d = a.d;
          state_d     = StIssue;
        end else if (b_pend) begin
          grant_b_d   = 1'b1;
          ram_we_d    = b.we;
          ram_addr_d  = b.a;
          ram_wdata_d = b.d;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        ram_req_d = ~ram_req_q;
        state_d   = StWait;
      end

      StWait: begin
        if (ram.ack == ram_req_q) begin
          if (!ram_we_q) begin
            if (grant_b_q) b_rdata_d = ram.q;
            else           a_rdata_d = ram.q;
          end
          // Ack takes the live req level rather than inverting itself, so an illegal
          // extra toggle during service merges into this transaction instead of
          // leaving the client pending again.
          if (grant_b_q) b_ack_d = b.req;
          else           a_ack_d = a.req;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      // Sync both handshakes to their peers so that nothing is pending after release.
      ram_req_q   <= ram.ack;
      a_ack_q     <= a.req;
      b_ack_q     <= b.req;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h00;
      a_rdata_q   <= 8'h00;
      b_rdata_q   <= 8'h00;
      grant_b_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      grant_b_q   <= grant_b_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a table of single transactions, hand-written
// arbitration, reset and protocol sequences, and a saturation run with random RAM latency.
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.a_bits(24)) ifa ();
  sdram_port_arbiter_if #(.a_bits(24)) ifb ();
  sdram_port_arbiter_if #(.a_bits(24)) ifr ();

  sdram_port_arbiter #(.a_bits(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (ifa),
    .b       (ifb),
    .ram     (ifr)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
  endtask

  // ---------------- RAM model ----------------
  logic [7:0] mem [logic [23:0]];
  function automatic logic [7:0] rd(input logic [23:0] ad);
    if (mem.exists(ad)) return mem[ad];
    return ad[7:0];
  endfunction

  typedef struct {
    bit          we;
    logic [23:0] a;
    logic [7:0]  d;
    int          cyc;
  } ram_rec_t;

  ram_rec_t ram_log[$];
  int ram_lat = 5;     // 0 selects a random latency of 1..10
  bit ram_busy = 1'b0;
  int ram_txn = 0;
  int stab_err = 0;

  initial begin
    ram_rec_t r;
    int lat;
    int k;
    bit aborted;
    ifr.ack = 1'b1;    // reset happens with ram_ack high
    ifr.q   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && (ifr.req != ifr.ack)) begin
        r.we = ifr.we;
        r.a = ifr.a;
        r.d = ifr.d;
        r.cyc = cyc;
        ram_log.push_back(r);
        ram_txn++;
        ram_busy = 1'b1;
        lat = (ram_lat == 0) ? int'($urandom_range(10, 1)) : ram_lat;
        aborted = 1'b0;
        k = 1;
        while (k < lat && !aborted) begin
          @(posedge clk);
          #1;
          if (ifr.req == ifr.ack) aborted = 1'b1;
          else if (ifr.we != r.we || ifr.a != r.a || ifr.d != r.d) stab_err++;
          k++;
        end
        if (!aborted) begin
          if (r.we) mem[r.a] = r.d;
          else ifr.q = rd(r.a);
          ifr.ack = ~ifr.ack;
        end
        ram_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  bit grant_log[$];
  int ack_toggles = 0;

  initial begin
    bit pa, pb;
    logic [7:0] e;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pa = ifa.ack;
        pb = ifb.ack;
      end else begin
        if (ifa.ack != pa) begin
          pa = ifa.ack;
          ack_toggles++;
          grant_log.push_back(1'b0);
          if (sb_a.size() == 0) fail("a_ack_unexpected");
          else begin
            e = sb_a.pop_front();
            check("a_q", 32'(ifa.q), 32'(e));
          end
        end
        if (ifb.ack != pb) begin
          pb = ifb.ack;
          ack_toggles++;
          grant_log.push_back(1'b1);
          if (sb_b.size() == 0) fail("b_ack_unexpected");
          else begin
            e = sb_b.pop_front();
            check("b_q", 32'(ifb.q), 32'(e));
          end
        end
      end
    end
  end

  // Call #1 after a rising edge; pushes the expected q for when ack comes back.
  task automatic issue(input bit cl, input bit we, input logic [23:0] ad, input logic [7:0] d,
                       input logic [7:0] exp_q);
    if (!cl) begin
      ifa.we = we; ifa.a = ad; ifa.d = d; ifa.req = ~ifa.req;
      sb_a.push_back(exp_q);
    end else begin
      ifb.we = we; ifb.a = ad; ifb.d = d; ifb.req = ~ifb.req;
      sb_b.push_back(exp_q);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0 || ram_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) fail("wait_done");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb_a.delete();
    sb_b.delete();
    ram_log.delete();
  endtask

  task automatic client_run(input bit cl, input int n);
    logic [23:0] ad;
    logic [7:0] v;
    int bud;
    for (int i = 0; i < n; i++) begin
      ad = (cl ? 24'h200000 : 24'h100000) + 24'(i);
      v = 8'($urandom);
      mem[ad] = v;
      issue(cl, 1'b0, ad, 8'h00, v);
      bud = 0;
      do begin
        @(posedge clk);
        #1;
        bud++;
      end while ((cl ? (ifb.req != ifb.ack) : (ifa.req != ifa.ack)) && bud < 100);
      if (bud >= 100) begin
        fail("sat_client_timeout");
        return;
      end
    end
  endtask

  typedef struct {
    bit          cl;
    bit          we;
    logic [23:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rq;
    int          lat;
    logic [7:0]  exp_q;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    ram_rec_t r;
    int n0, c0, t0, viol, g0;
    bit other0;

    vecs[0] = '{cl: 1'b0, we: 1'b0, addr: 24'h123456, wd: 8'h00, rq: 8'hA5, lat: 5, exp_q: 8'hA5};
    vecs[1] = '{cl: 1'b1, we: 1'b1, addr: 24'h000010, wd: 8'h3C, rq: 8'h00, lat: 3, exp_q: 8'h00};
    vecs[2] = '{cl: 1'b1, we: 1'b0, addr: 24'hFFFFFF, wd: 8'h11, rq: 8'h7E, lat: 1, exp_q: 8'h7E};
    vecs[3] = '{cl: 1'b0, we: 1'b1, addr: 24'h000000, wd: 8'hFF, rq: 8'h00, lat: 10, exp_q: 8'hA5};
    vecs[4] = '{cl: 1'b1, we: 1'b1, addr: 24'hABCDEF, wd: 8'h00, rq: 8'h00, lat: 2, exp_q: 8'h7E};
    vecs[5] = '{cl: 1'b0, we: 1'b0, addr: 24'h800000, wd: 8'hC3, rq: 8'h5A, lat: 1, exp_q: 8'h5A};

    ifa.req = 1'b0; ifa.we = 1'b0; ifa.a = '0; ifa.d = 8'h00;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.a = '0; ifb.d = 8'h00;

    // Reset state, with ram_ack held high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_req", 32'(ifr.req), 32'd1);
    check("rst_a_ack", 32'(ifa.ack), 32'(ifa.req));
    check("rst_b_ack", 32'(ifb.ack), 32'(ifb.req));
    check("rst_a_q", 32'(ifa.q), 32'h0);
    check("rst_b_q", 32'(ifb.q), 32'h0);
    check("rst_ram_we", 32'(ifr.we), 32'h0);
    check("rst_ram_a", 32'(ifr.a), 32'h0);
    check("rst_ram_d", 32'(ifr.d), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_ram_txn", 32'(ram_txn), 32'd0);
    check("post_rst_ram_sync", 32'(ifr.req), 32'(ifr.ack));

    // Table of single transactions.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if (!v.we) mem[v.addr] = v.rq;
      ram_lat = v.lat;
      other0 = v.cl ? ifa.ack : ifb.ack;
      n0 = ram_txn;
      c0 = cyc;
      issue(v.cl, v.we, v.addr, v.wd, v.exp_q);
      wait_done(300);
      check("vec_ram_txn", 32'(ram_txn - n0), 32'd1);
      if (ram_log.size() > 0) begin
        r = ram_log.pop_front();
        check("vec_ram_we", 32'(r.we), 32'(v.we));
        check("vec_ram_a", 32'(r.a), 32'(v.addr));
        check("vec_ram_d", 32'(r.d), 32'(v.wd));
        check("vec_issue_latency", 32'(r.cyc - c0), 32'd2);
      end else fail("vec_ram_log");
      check("vec_other_ack", 32'(v.cl ? ifa.ack : ifb.ack), 32'(other0));
      check("vec_q", 32'(v.cl ? ifb.q : ifa.q), 32'(v.exp_q));
    end

    // Simultaneous requests from reset: A wins, then B.
    do_reset();
    ram_log.delete();
    ram_lat = 2;
    mem[24'h0A0000] = 8'h11;
    mem[24'h0B0000] = 8'h22;
    grant_log.delete();
    issue(1'b0, 1'b0, 24'h0A0000, 8'h00, 8'h11);
    issue(1'b1, 1'b0, 24'h0B0000, 8'h00, 8'h22);
    wait_done(200);
    if (grant_log.size() == 2) begin
      check("rr1_first", 32'(grant_log[0]), 32'd0);
      check("rr1_second", 32'(grant_log[1]), 32'd1);
    end else fail("rr1_grant_count");
    // A alone, so A was granted last; the next tie must go to B.
    mem[24'h0A0001] = 8'h33;
    issue(1'b0, 1'b0, 24'h0A0001, 8'h00, 8'h33);
    wait_done(200);
    mem[24'h0A0002] = 8'h44;
    mem[24'h0B0002] = 8'h55;
    grant_log.delete();
    issue(1'b0, 1'b0, 24'h0A0002, 8'h00, 8'h44);
    issue(1'b1, 1'b0, 24'h0B0002, 8'h00, 8'h55);
    wait_done(200);
    if (grant_log.size() == 2) begin
      check("rr2_first", 32'(grant_log[0]), 32'd1);
      check("rr2_second", 32'(grant_log[1]), 32'd0);
    end else fail("rr2_grant_count");
    ram_log.delete();

    // Extra toggle while pending is folded into the transaction in flight.
    ram_lat = 6;
    n0 = ram_txn;
    t0 = ack_toggles;
    ifa.we = 1'b1; ifa.a = 24'h000777; ifa.d = 8'h99; ifa.req = ~ifa.req;
    repeat (4) @(posedge clk);
    #1;
    ifa.req = ~ifa.req;
    repeat (20) @(posedge clk);
    #1;
    check("dbl_toggle_ram_txn", 32'(ram_txn - n0), 32'd1);
    check("dbl_toggle_not_pending", 32'(ifa.ack), 32'(ifa.req));
    check("dbl_toggle_ack_moves", 32'(ack_toggles - t0), 32'd0);
    if (ram_log.size() == 1) begin
      r = ram_log.pop_front();
      check("dbl_toggle_ram_d", 32'(r.d), 32'h99);
    end else fail("dbl_toggle_ram_log");
    ram_log.delete();

    // Saturation: 100 back-to-back reads per client, random latency.
    ram_lat = 0;
    n0 = ram_txn;
    g0 = grant_log.size();
    stab_err = 0;
    fork
      client_run(1'b0, 100);
      client_run(1'b1, 100);
    join
    wait_done(200);
    check("sat_ram_txn", 32'(ram_txn - n0), 32'd200);
    check("sat_grants", 32'(grant_log.size() - g0), 32'd200);
    viol = 0;
    for (int i = g0 + 1; i < grant_log.size(); i++)
      if (grant_log[i] == grant_log[i-1]) viol++;
    check("sat_alternate", 32'(viol), 32'd0);
    check("ram_bus_stable", 32'(stab_err), 32'd0);
    ram_log.delete();

    // Reset during WAIT with ram_ack lagging.
    ram_lat = 20;
    n0 = ram_txn;
    mem[24'h0000AA] = 8'h33;
    issue(1'b0, 1'b0, 24'h0000AA, 8'h00, 8'h33);
    repeat (6) @(posedge clk);
    #1;
    check("rst_wait_busy", 32'(ram_busy), 32'd1);
    do_reset();
    t0 = ack_toggles;
    repeat (5) @(posedge clk);
    #1;
    check("rst_wait_a_sync", 32'(ifa.ack), 32'(ifa.req));
    check("rst_wait_ram_sync", 32'(ifr.req), 32'(ifr.ack));
    check("rst_wait_a_q", 32'(ifa.q), 32'h0);
    check("rst_wait_no_ack", 32'(ack_toggles - t0), 32'd0);
    check("rst_wait_ram_txn", 32'(ram_txn - n0), 32'd1);
    check("rst_wait_ram_idle", 32'(ram_busy), 32'd0);
    ram_lat = 3;
    mem[24'h0000AB] = 8'hE7;
    issue(1'b0, 1'b0, 24'h0000AB, 8'h00, 8'hE7);
    wait_done(200);
    check("rst_wait_read_q", 32'(ifa.q), 32'hE7);
    check("rst_wait_read_toggles", 32'(ack_toggles - t0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
